replicacao_de_pixels: RTL

- 2x zoom-in (upscale) block: the inverse operation of the team's 2x2 block-average zoom-out.
- Each input pixel is replicated into a 2x2 output block by nearest-neighbour replication. Output image is 2W x 2H.
- Sits in the same coprocessor image path as the zoom-out block and shares its start/done and pixel-stream conventions.
- A one-line buffer holds the current input row so it can be replayed for the second output row.

---
 rtl/replicacao_de_pixels_pkg.sv | 27 ++
 rtl/replicacao_de_pixels_linha_buffer.sv | 27 ++
 rtl/replicacao_de_pixels.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/replicacao_de_pixels_pkg.sv
// Shared constants and state encoding for the coprocessor image path
// (zoom-in replication and zoom-out block average).
package replicacao_de_pixels_pkg;

   localparam int LARGURA_MAXIMA       = 320;
   localparam int LARGURA_MAXIMA_SAIDA = 640;
   localparam int LARGURA_BITS         = 10;
   localparam int PIXEL_BITS           = 8;
   localparam int ENDERECO_BITS        = $clog2(LARGURA_MAXIMA);
   localparam int CONTADOR_BITS        = 20;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RECEBE = 2'd1,
      S_REPETE = 2'd2
   } estado_t;

   function automatic logic [LARGURA_BITS-1:0] limita_largura(
      input logic [LARGURA_BITS-1:0] largura
   );
      if (largura > LARGURA_BITS'(LARGURA_MAXIMA)) begin
         return LARGURA_BITS'(LARGURA_MAXIMA);
      end
      return largura;
   endfunction

endpackage

// File: rtl/replicacao_de_pixels_linha_buffer.sv
// linha_buffer_rw: single-port line buffer, synchronous write, registered read.
// Contents are deliberately not reset.
module linha_buffer_rw
   import replicacao_de_pixels_pkg::*;
#(
   parameter int PROFUNDIDADE = LARGURA_MAXIMA
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [ENDERECO_BITS-1:0] i_endereco,
   input  logic [PIXEL_BITS-1:0]    i_dado,
   output logic [PIXEL_BITS-1:0]    o_dado
);

   logic [PIXEL_BITS-1:0] r_mem [0:PROFUNDIDADE-1];
   logic [PIXEL_BITS-1:0] r_dado;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_endereco] <= i_dado;
      end
      r_dado <= r_mem[i_endereco];
   end

   assign o_dado = r_dado;

endmodule

// File: rtl/replicacao_de_pixels.sv
// 2x nearest-neighbour upscaler: each input pixel becomes a 2x2 output block.
// Optional macro REPLICACAO_CONTADOR_EN adds the pixels_emitidos output counter.
module replicacao_de_pixels
   import replicacao_de_pixels_pkg::*;
(
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [LARGURA_BITS-1:0] largura_in,
   input  logic [LARGURA_BITS-1:0] altura_in,
   input  logic [PIXEL_BITS-1:0]   pixel_in,
   input  logic                    pixel_in_valid,
   output logic                    pixel_in_ready,
   output logic [PIXEL_BITS-1:0]   pixel_out,
   output logic                    pixel_out_valid,
   output logic                    processing_done,
   output estado_t                 estado_dbg
`ifdef REPLICACAO_CONTADOR_EN
   ,
   output logic [CONTADOR_BITS-1:0] pixels_emitidos
`endif
);

   // Handshake: a pixel transfers on a rising edge where pixel_in_valid and
   // pixel_in_ready are both high; ready depends on registers only, and the
   // output stream has no backpressure.

   estado_t                  r_estado;
   estado_t                  w_estado_prox;
   logic [LARGURA_BITS-1:0]  r_x;
   logic [LARGURA_BITS-1:0]  r_y;
   logic                     r_fase;
   logic [LARGURA_BITS-1:0]  r_largura;
   logic [LARGURA_BITS-1:0]  r_altura;
   logic [PIXEL_BITS-1:0]    r_hold;

   logic [LARGURA_BITS-1:0]  w_largura_lim;
   logic                     w_dim_zero;
   logic                     w_ultimo_x;
   logic                     w_ultima_linha;
   logic [LARGURA_BITS-1:0]  w_x_prox;
   logic                     w_aceita;
   logic                     w_buf_we;
   logic [ENDERECO_BITS-1:0] w_buf_end;
   logic [PIXEL_BITS-1:0]    w_buf_dado;

   assign w_largura_lim  = limita_largura(largura_in);
   assign w_dim_zero     = (w_largura_lim == '0) || (altura_in == '0);
   assign w_ultimo_x     = (r_x == r_largura - LARGURA_BITS'(1));
   assign w_ultima_linha = (r_y == r_altura - LARGURA_BITS'(1));
   assign w_x_prox       = w_ultimo_x ? '0 : r_x + LARGURA_BITS'(1);
   assign w_aceita       = pixel_in_ready && pixel_in_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_estado <= S_IDLE;
      end else begin
         r_estado <= w_estado_prox;
      end
   end

   always_comb begin
      w_estado_prox = r_estado;
      unique case (r_estado)
         S_IDLE: begin
            if (start && !w_dim_zero) begin
               w_estado_prox = S_RECEBE;
            end
         end
         S_RECEBE: begin
            if (r_fase && w_ultimo_x) begin
               w_estado_prox = S_REPETE;
            end
         end
         S_REPETE: begin
            if (r_fase && w_ultimo_x) begin
               w_estado_prox = w_ultima_linha ? S_IDLE : S_RECEBE;
            end
         end
         default: w_estado_prox = S_IDLE;
      endcase
   end

   // On fase 1 the buffer already addresses the next column, so the
   // registered read data is ready for the following replay cycle.
   always_comb begin
      pixel_in_ready = (r_estado == S_RECEBE) && !r_fase;
      estado_dbg     = r_estado;
      w_buf_we       = w_aceita;
      w_buf_end      = r_fase ? w_x_prox[ENDERECO_BITS-1:0] : r_x[ENDERECO_BITS-1:0];
   end

   linha_buffer_rw #(
      .PROFUNDIDADE (LARGURA_MAXIMA)
   ) u_linha_buffer (
      .i_clk      (clk),
      .i_we       (w_buf_we),
      .i_endereco (w_buf_end),
      .i_dado     (pixel_in),
      .o_dado     (w_buf_dado)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_x             <= '0;
         r_y             <= '0;
         r_fase          <= 1'b0;
         r_largura       <= '0;
         r_altura        <= '0;
         r_hold          <= '0;
         pixel_out       <= '0;
         pixel_out_valid <= 1'b0;
         processing_done <= 1'b0;
      end else begin
         pixel_out_valid <= 1'b0;
         processing_done <= 1'b0;
         unique case (r_estado)
            S_IDLE: begin
               if (start) begin
                  r_largura <= w_largura_lim;
                  r_altura  <= altura_in;
                  r_x       <= '0;
                  r_y       <= '0;
                  r_fase    <= 1'b0;
                  if (w_dim_zero) begin
                     processing_done <= 1'b1;
                  end
               end
            end
            S_RECEBE: begin
               if (!r_fase) begin
                  if (pixel_in_valid) begin
                     pixel_out       <= pixel_in;
                     pixel_out_valid <= 1'b1;
                     r_hold          <= pixel_in;
                     r_fase          <= 1'b1;
                  end
               end else begin
                  pixel_out       <= r_hold;
                  pixel_out_valid <= 1'b1;
                  r_fase          <= 1'b0;
                  r_x             <= w_x_prox;
               end
            end
            S_REPETE: begin
               if (!r_fase) begin
                  pixel_out       <= w_buf_dado;
                  pixel_out_valid <= 1'b1;
                  r_hold          <= w_buf_dado;
                  r_fase          <= 1'b1;
               end else begin
                  pixel_out       <= r_hold;
                  pixel_out_valid <= 1'b1;
                  r_fase          <= 1'b0;
                  r_x             <= w_x_prox;
                  if (w_ultimo_x) begin
                     if (w_ultima_linha) begin
                        processing_done <= 1'b1;
                     end else begin
                        r_y <= r_y + LARGURA_BITS'(1);
                     end
                  end
               end
            end
            default: begin
               r_fase <= 1'b0;
            end
         endcase
      end
   end

`ifdef REPLICACAO_CONTADOR_EN
   logic                     w_emite;
   logic [CONTADOR_BITS-1:0] r_pixels_emitidos;

   // Counts on the same edge that raises pixel_out_valid, so it tracks the stream exactly.
   assign w_emite = ((r_estado == S_RECEBE) && (r_fase || pixel_in_valid)) ||
                    (r_estado == S_REPETE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pixels_emitidos <= '0;
      end else if ((r_estado == S_IDLE) && start) begin
         r_pixels_emitidos <= '0;
      end else if (w_emite && (r_pixels_emitidos != '1)) begin
         r_pixels_emitidos <= r_pixels_emitidos + CONTADOR_BITS'(1);
      end
   end

   assign pixels_emitidos = r_pixels_emitidos;
`endif

endmodule
